// File: rtl/d5m_gen_pkg.sv
// d5m_gen_pkg: shared FSM states, pattern modes, bar colours and sizing helpers for the D5M stream generator
package d5m_gen_pkg;
  typedef enum logic [2:0] {IDLE, VBLANK, FLEAD, ACTIVE, HBLANK, FTRAIL} state_t;
  localparam logic [1:0] RAMP  = 2'd0;
  localparam logic [1:0] BARS  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] CONST = 2'd3;
  // {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
  function automatic int imax(int a, int b);
    return a > b ? a : b;
  endfunction
  function automatic int cw(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/d5m_stream_gen_if.sv
// d5m_stream_gen_if: D5M parallel pixel stream bundle (transmit = master, capture = slave)
interface d5m_stream_gen_if;
  logic [11:0] data;
  logic fval;
  logic lval;
  modport master(output data, fval, lval);
  modport slave(input data, fval, lval);
endinterface

// File: rtl/d5m_pattern_lut.sv
// d5m_pattern_lut: pixel value for the selected test pattern at position (x, y); Bayer order is G R / B G
module d5m_pattern_lut
  import d5m_gen_pkg::*;
#(
  parameter int ACT_W = 1280,
  parameter int XW = 11,
  parameter int YW = 10
) (
  input  logic [1:0]    mode,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [11:0]   iCONST,
  output logic [11:0]   value
);
  logic [2:0] bar;
  logic [2:0] rgb;
  logic comp;
  logic xb4;
  logic yb4;
  assign bar = 3'((32'(x) * 8) / ACT_W);
  assign rgb = BAR_RGB[bar];
  assign comp = y[0] ? (x[0] ? rgb[1] : rgb[0]) : (x[0] ? rgb[2] : rgb[1]);
  assign xb4 = 1'(x >> 4);
  assign yb4 = 1'(y >> 4);
  assign value = mode == RAMP  ? 12'(x) :
                 mode == BARS  ? {12{comp}} :
                 mode == CHECK ? {12{xb4 ^ yb4}} : iCONST;
endmodule

// File: rtl/d5m_stream_gen.sv
// d5m_stream_gen: synthetic D5M FVAL/LVAL/12-bit pixel stream for camera-less capture bring-up
module d5m_stream_gen
  import d5m_gen_pkg::*;
#(
  parameter int ACT_W = 1280,
  parameter int ACT_H = 960,
  parameter int H_BLANK = 64,
  parameter int FV_LEAD = 16,
  parameter int FV_TRAIL = 16,
  parameter int V_BLANK = 1024
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEN,
  input  logic [1:0]  iMODE,
  input  logic [11:0] iCONST,
  output logic [11:0] oDATA,
  output logic        oFVAL,
  output logic        oLVAL,
  output logic [15:0] oFRAME_CNT,
  output logic        oBUSY
);
  localparam int XW = cw(ACT_W);
  localparam int YW = cw(ACT_H);
  localparam int TW = cw(imax(imax(V_BLANK, H_BLANK), imax(FV_LEAD, FV_TRAIL)));
  state_t state, state_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [TW-1:0] t, t_n;
  logic [1:0] mode, mode_n;
  logic [11:0] pix;
  logic fdone;
  assign fdone = state == FTRAIL && t == TW'(FV_TRAIL - 1);
  always_comb begin
    state_n = state;
    x_n = x;
    y_n = y;
    t_n = t + 1'b1;
    mode_n = mode;
    case (state)
      IDLE: begin
        t_n = '0;
        x_n = '0;
        y_n = '0;
        state_n = iEN ? VBLANK : IDLE;
      end
      VBLANK: if (t == TW'(V_BLANK - 1)) begin
        state_n = FLEAD;
        t_n = '0;
        x_n = '0;
        y_n = '0;
        mode_n = iMODE;
      end
      FLEAD: if (t == TW'(FV_LEAD - 1)) begin
        state_n = ACTIVE;
        t_n = '0;
      end
      ACTIVE: begin
        t_n = '0;
        x_n = x + 1'b1;
        if (x == XW'(ACT_W - 1)) begin
          x_n = '0;
          state_n = y == YW'(ACT_H - 1) ? FTRAIL : HBLANK;
          y_n = y == YW'(ACT_H - 1) ? y : y + 1'b1;
        end
      end
      HBLANK: if (t == TW'(H_BLANK - 1)) begin
        state_n = ACTIVE;
        t_n = '0;
      end
      FTRAIL: if (fdone) begin
        state_n = iEN ? VBLANK : IDLE;
        t_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from next-state values so they line up with the state register
  d5m_pattern_lut #(.ACT_W(ACT_W), .XW(XW), .YW(YW)) u_lut (
    .mode(mode_n),
    .x(x_n),
    .y(y_n),
    .iCONST(iCONST),
    .value(pix)
  );
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      t <= '0;
      mode <= RAMP;
      oDATA <= '0;
      oFVAL <= 1'b0;
      oLVAL <= 1'b0;
      oFRAME_CNT <= '0;
      oBUSY <= 1'b0;
    end else begin
      state <= state_n;
      x <= x_n;
      y <= y_n;
      t <= t_n;
      mode <= mode_n;
      oDATA <= state_n == ACTIVE ? pix : '0;
      oFVAL <= state_n inside {FLEAD, ACTIVE, HBLANK, FTRAIL};
      oLVAL <= state_n == ACTIVE;
      oFRAME_CNT <= oFRAME_CNT + 16'(fdone);
      oBUSY <= state_n != IDLE;
    end
  end
endmodule
